// File: rtl/alu_cmd_seq.sv
// Command sequencer for an external 4-bit ALU, with a 4x4-bit register file and a held response.
// Optional: define ALU_CMD_SEQ_PERF_EN to add the op_count handshake counter output.
module alu_cmd_seq #(
    parameter int unsigned ISSUE_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    // Both handshakes: a transfer happens on a rising edge where valid=1 and ready=1;
    // the sender holds its payload stable while valid=1 and ready=0.
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_ra,
    input  logic [1:0] cmd_rb,
    input  logic [3:0] cmd_imm,
    input  logic       cmd_use_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [3:0] alu_results,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_zero,
    output logic       rsp_carry,
    output logic [1:0] state_dbg  // 0 IDLE, 1 ISSUE, 2 CAPTURE, 3 RESP
`ifdef ALU_CMD_SEQ_PERF_EN
    ,
    output logic [7:0] op_count
`endif
);

    localparam logic [2:0] OP_LOAD   = 3'b111;
    localparam logic [3:0] WAIT_LAST = 4'(ISSUE_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [3:0] wait_cnt;
    logic [3:0] regs [0:3];
    logic [1:0] lat_rd;
    logic [3:0] lat_imm;
    logic       lat_load;
    logic       accept;
    logic       rsp_hs;

    assign accept    = cmd_valid && (state == IDLE);
    assign rsp_hs    = rsp_ready && (state == RESP);
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_valid) state_next = (cmd_op == OP_LOAD) ? CAPTURE : ISSUE;
            end
            ISSUE: begin
                if (wait_cnt == WAIT_LAST) state_next = CAPTURE;
            end
            CAPTURE: state_next = RESP;
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts the cycles spent in ISSUE so the operands are held ISSUE_WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              wait_cnt <= '0;
        else if (accept)         wait_cnt <= '0;
        else if (state == ISSUE) wait_cnt <= wait_cnt + 4'd1;
    end

    // Sources are read at accept, so rd==ra/rb sees the old register value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            lat_rd     <= '0;
            lat_imm    <= '0;
            lat_load   <= 1'b0;
        end else if (accept) begin
            lat_rd   <= cmd_rd;
            lat_imm  <= cmd_imm;
            lat_load <= (cmd_op == OP_LOAD);
            if (cmd_op != OP_LOAD) begin
                alu_a      <= regs[cmd_ra];
                alu_b      <= cmd_use_imm ? cmd_imm : regs[cmd_rb];
                alu_opcode <= cmd_op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
        end else if (state == CAPTURE) begin
            if (lat_load) begin
                regs[lat_rd] <= lat_imm;
                rsp_data     <= lat_imm;
                rsp_zero     <= (lat_imm == 4'd0);
                rsp_carry    <= 1'b0;
            end else begin
                regs[lat_rd] <= alu_results;
                rsp_data     <= alu_results;
                rsp_zero     <= alu_zero;
                rsp_carry    <= alu_carry;
            end
        end
    end

`ifdef ALU_CMD_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      op_count <= '0;
        else if (rsp_hs) op_count <= op_count + 8'd1;
    end
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Randomized self-checking bench for alu_cmd_seq: models the external ALU and a register-file reference.
// Define ALU_CMD_SEQ_PERF_EN to also check the op_count output.
module tb_alu_cmd_seq;
  localparam int unsigned IW = 1;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [3:0] cmd_imm;
  logic       cmd_use_imm;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_results;
  logic       alu_zero, alu_carry;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_zero, rsp_carry;
  logic [1:0] state_dbg;
`ifdef ALU_CMD_SEQ_PERF_EN
  logic [7:0] op_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [3:0] m_regs [0:3];
  logic [3:0] m_a, m_b;
  logic [2:0] m_op;
  int         m_ops;

  // Expected response queue: {carry, zero, data}
  logic [5:0] exp_q[$];

  alu_cmd_seq #(.ISSUE_WAIT(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_results(alu_results), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .state_dbg(state_dbg)
`ifdef ALU_CMD_SEQ_PERF_EN
    , .op_count(op_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: returns {carry, zero, result}
  function automatic logic [5:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] wide;
    logic [3:0] r;
    logic       c;
    c = 1'b0;
    case (op)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[3:0]; c = wide[4]; end
      3'd1: begin wide = {1'b0, a} - {1'b0, b}; r = wide[3:0]; c = wide[4]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = (a > b) ? 4'd1 : 4'd0;
      default: r = 4'd0;
    endcase
    return {c, (r == 4'd0), r};
  endfunction

  always_comb {alu_carry, alu_zero, alu_results} = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_a = 4'd0; m_b = 4'd0; m_op = 3'd0; m_ops = 0;
    exp_q.delete();
  endtask

  task automatic junk_cmd_fields();
    cmd_op      = 3'($urandom_range(0, 7));
    cmd_rd      = 2'($urandom_range(0, 3));
    cmd_ra      = 2'($urandom_range(0, 3));
    cmd_rb      = 2'($urandom_range(0, 3));
    cmd_imm     = 4'($urandom_range(0, 15));
    cmd_use_imm = 1'($urandom_range(0, 1));
  endtask

  // Driver: issue one command from IDLE, hold rsp_ready low 'hold' cycles in RESP, then complete.
  // Called and returns at a negedge.
  task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [3:0] imm, input logic use_imm,
                        input int hold);
    logic [3:0] a, b;
    logic [5:0] exp_rsp;
    int         lat, exp_lat;
    a = m_regs[ra];
    b = use_imm ? imm : m_regs[rb];
    if (op == 3'd7) begin
      exp_rsp = {1'b0, (imm == 4'd0), imm};
      exp_lat = 2;
    end else begin
      exp_rsp = alu_fn(op, a, b);
      exp_lat = int'(IW) + 2;
      m_a = a; m_b = b; m_op = op;
    end
    exp_q.push_back(exp_rsp);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm; cmd_use_imm = use_imm;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    junk_cmd_fields();
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      check("cmd_ready_busy", cmd_ready, 0);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_opcode", alu_opcode, m_op);
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", lat, exp_lat);
    exp_rsp = exp_q.pop_front();
    rsp_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      check("rsp_data", rsp_data, exp_rsp[3:0]);
      check("rsp_zero", rsp_zero, exp_rsp[4]);
      check("rsp_carry", rsp_carry, exp_rsp[5]);
      check("rsp_valid_hold", rsp_valid, 1);
      check("cmd_ready_resp", cmd_ready, 0);
      cmd_valid = 1'b1;
      junk_cmd_fields();
      @(negedge clk);
    end
    check("rsp_data", rsp_data, exp_rsp[3:0]);
    check("rsp_zero", rsp_zero, exp_rsp[4]);
    check("rsp_carry", rsp_carry, exp_rsp[5]);
    check("rsp_valid_hs", rsp_valid, 1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    m_regs[rd] = exp_rsp[3:0];
    m_ops++;
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("cmd_ready_after_hs", cmd_ready, 1);
`ifdef ALU_CMD_SEQ_PERF_EN
    check("op_count", op_count, m_ops % 256);
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_flags", {rsp_zero, rsp_carry}, 0);
    check("rst_state_dbg", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    junk_cmd_fields();
    @(negedge clk);
    apply_reset();

    // ADD with carry wrap, result read back through r2
    do_cmd(3'd7, 2'd0, 2'd0, 2'd0, 4'd9, 1'b0, 0);
    do_cmd(3'd7, 2'd1, 2'd0, 2'd0, 4'd8, 1'b0, 0);
    do_cmd(3'd0, 2'd2, 2'd0, 2'd1, 4'd0, 1'b0, 0);
    check("add_rsp_data", rsp_data, 4'd1);
    check("add_rsp_carry", rsp_carry, 1);
    do_cmd(3'd3, 2'd3, 2'd2, 2'd0, 4'd0, 1'b1, 1);
    check("reg2_readback", rsp_data, 4'd1);

    // SUB with borrow, compare, XOR self, LOAD zero
    do_cmd(3'd7, 2'd0, 2'd0, 2'd0, 4'd3, 1'b0, 0);
    do_cmd(3'd1, 2'd3, 2'd0, 2'd0, 4'd5, 1'b1, 0);
    check("sub_rsp_data", rsp_data, 4'he);
    do_cmd(3'd6, 2'd3, 2'd0, 2'd0, 4'd2, 1'b1, 0);
    check("cmp_rsp_data", rsp_data, 4'd1);
    do_cmd(3'd4, 2'd1, 2'd0, 2'd0, 4'd0, 1'b0, 0);
    check("xor_rsp_zero", rsp_zero, 1);
    do_cmd(3'd7, 2'd2, 2'd0, 2'd0, 4'd0, 1'b0, 0);
    check("load0_rsp_zero", rsp_zero, 1);

    // Long response stall with competing cmd_valid
    do_cmd(3'd2, 2'd0, 2'd0, 2'd3, 4'd0, 1'b0, 5);

    // Reset during ISSUE of ADD rd=3
    do_cmd(3'd7, 2'd3, 2'd0, 2'd0, 4'd7, 1'b0, 0);
    cmd_op = 3'd0; cmd_rd = 2'd3; cmd_ra = 2'd3; cmd_rb = 2'd3; cmd_use_imm = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_issue_busy", cmd_ready, 0);
    apply_reset();
    check("post_rst_ready", cmd_ready, 1);
    do_cmd(3'd3, 2'd0, 2'd3, 2'd0, 4'd0, 1'b1, 0);
    check("reg3_after_rst", rsp_data, 4'd0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      do_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)));
    end

`ifdef ALU_CMD_SEQ_PERF_EN
    apply_reset();
    for (int n = 0; n < 257; n++) begin
      do_cmd(3'd7, 2'($urandom_range(0, 3)), 2'd0, 2'd0, 4'($urandom_range(0, 15)), 1'b0, 0);
    end
    check("op_count_wrap", op_count, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter ISSUE_WAIT, default 1, meaning: number of cycles (1..15) that ALU operands are held before the ALU outputs are sampled.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  block can accept a command.
REQ-006 cmd_op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 A>B compare, 111 LOAD immediate.
REQ-007 cmd_rd, cmd_ra, cmd_rb  in  2 each  destination and source register indices.
REQ-008 cmd_imm  in  4  immediate value, used by LOAD or when cmd_use_imm=1.
REQ-009 cmd_use_imm  in  1  1 = B operand is cmd_imm instead of reg[cmd_rb].
REQ-010 alu_a, alu_b  out  4 each  registered operands to the external 4-bit ALU.
REQ-011 alu_opcode  out  3  registered opcode to the external ALU.
REQ-012 alu_results  in  4; alu_zero  in  1; alu_carry  in  1  combinational ALU outputs.
REQ-013 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-014 rsp_data  out  4; rsp_zero  out  1; rsp_carry  out  1  captured result and flags.

Function
REQ-015 Four-entry 4-bit register file reg[0..3]; the FSM has four states: IDLE, ISSUE, CAPTURE, RESP.
REQ-016 cmd_ready shall be 1 only in IDLE; a command is accepted on a cycle with cmd_valid=1 and cmd_ready=1, and all cmd_* fields are latched on that edge.
REQ-017 Non-LOAD accept: the FSM goes IDLE->ISSUE; on the same edge alu_a=reg[ra], alu_b=(use_imm ? imm : reg[rb]) and alu_opcode=cmd_op are latched, using register values from before the edge.
REQ-018 ISSUE lasts exactly ISSUE_WAIT cycles, then goes to CAPTURE; alu_a, alu_b and alu_opcode are stable throughout ISSUE.
REQ-019 LOAD accept (op 111): the FSM goes IDLE->CAPTURE directly; the ALU outputs are not sampled and alu_* outputs keep their previous values.
REQ-020 CAPTURE (one cycle): for non-LOAD, reg[rd], rsp_data, rsp_zero and rsp_carry are written from alu_results, alu_zero and alu_carry; for LOAD, they are written with imm, (imm==0) and 0. The FSM then goes to RESP.
REQ-021 RESP: rsp_valid=1 and rsp_* are held stable until rsp_ready=1; the handshake edge returns the FSM to IDLE with rsp_valid=0.
REQ-022 rsp_ready=1 on the first RESP cycle completes the handshake in that cycle.
REQ-023 Accept-to-rsp_valid latency: non-LOAD takes ISSUE_WAIT+2 cycles; LOAD takes 2 cycles.
REQ-024 Back-to-back throughput: a new command is accepted no earlier than the cycle after the rsp handshake; commands are never dropped or overlapped.
REQ-025 rd equal to ra or rb: sources are read at accept, and rd is written only in CAPTURE.
REQ-026 cmd_* changes while cmd_ready=0 shall have no effect.
REQ-027 rsp_ready while not in RESP shall be ignored.

Reset
REQ-028 While rst_n=0, the block asynchronously sets: state=IDLE, reg[0..3]=0, alu_a=0, alu_b=0, alu_opcode=000, rsp_data=0, rsp_zero=0, rsp_carry=0, rsp_valid=0.
REQ-029 cmd_ready is 1 from reset deassertion.
REQ-030 Reset in any state aborts the operation in flight; no partial register write survives and no response is produced.

Configuration
REQ-031 Macro ALU_CMD_SEQ_PERF_EN; when defined, the block adds output op_count (8 bits), which resets to 0 and increments by 1 on each rsp handshake, wrapping 255->0.
REQ-032 When ALU_CMD_SEQ_PERF_EN is undefined, op_count and its logic are absent and all other behaviour is identical.

Verification
REQ-033 LOAD r0=9, then LOAD r1=8, then ADD rd=2 ra=0 rb=1 -> rsp_data=1, rsp_carry=1, rsp_zero=0, reg[2]=1, and rsp_valid rises 3 cycles after the ADD accept (ISSUE_WAIT=1).
REQ-034 r0=3, SUB ra=0 with imm=5 and use_imm=1 -> rsp_data=0xE, rsp_carry=1; then compare r0 with imm=2 -> rsp_data=1, rsp_zero=0.
REQ-035 XOR r0 with r0 (value 3) -> rsp_data=0, rsp_zero=1, rsp_carry=0; LOAD imm=0 -> rsp_zero=1.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, cmd_ready=0, and a new cmd_valid is not accepted; rsp_ready=1 -> IDLE on the next cycle.
REQ-037 Assert rst_n=0 during ISSUE of ADD rd=3 -> reg[3]=0, rsp_valid=0, cmd_ready=1 after release.
REQ-038 With ALU_CMD_SEQ_PERF_EN defined, 257 LOADs -> op_count=1.
